// File: rtl/sysarray_result_drain.sv
// Result unloader for the 4x4 dual-bank systolic array: snapshots both result
// banks on `done` and streams them out one element per valid/ready transfer.
module sysarray_result_drain #(
   parameter int WIDTH     = 8,
   parameter int SAT_BANK1 = 1
) (
   input  logic                    clk,
   input  logic                    _reset,
   input  logic                    done,
   input  logic [16*2*WIDTH-1:0]   result1_flat,
   input  logic [16*2*WIDTH-1:0]   result2_flat,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*WIDTH-1:0]      out_data,
   output logic                    out_bank,
   output logic [1:0]              out_row,
   output logic [1:0]              out_col,
   output logic                    out_last,
   output logic                    busy,
   output logic                    overrun,
   output logic [1:0]              dbg_state
);

   localparam int EW = 2 * WIDTH;
   localparam logic [EW-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [EW-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SEND1 = 2'd1,
      ST_SEND2 = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [3:0]    index, index_n;
   logic          capture;
   logic          overrun_set;
   logic          xfer;
   logic [EW-1:0] snap1 [16];
   logic [EW-1:0] snap2 [16];
   logic [EW-1:0] raw1, raw2, sat1;

   // Handshake: an element moves on a rising edge where out_valid && out_ready;
   // while out_valid is high and out_ready low, data and tags hold, and
   // out_valid only falls after a transfer (or on reset).
   assign xfer = out_valid & out_ready;

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state   <= ST_IDLE;
         index   <= 4'd0;
         overrun <= 1'b0;
         for (int k = 0; k < 16; k++) begin
            snap1[k] <= '0;
            snap2[k] <= '0;
         end
      end else begin
         state <= state_n;
         index <= index_n;
         if (overrun_set) overrun <= 1'b1;
         if (capture) begin
            for (int k = 0; k < 16; k++) begin
               snap1[k] <= result1_flat[k*EW +: EW];
               snap2[k] <= result2_flat[k*EW +: EW];
            end
         end
      end
   end

   always_comb begin
      state_n     = state;
      index_n     = index;
      capture     = 1'b0;
      overrun_set = 1'b0;
      case (state)
         ST_IDLE: begin
            if (done) begin
               capture = 1'b1;
               state_n = ST_SEND1;
               index_n = 4'd0;
            end
         end
         ST_SEND1: begin
            if (done) overrun_set = 1'b1;
            if (xfer) begin
               index_n = index + 4'd1;
               if (index == 4'd15) state_n = ST_SEND2;
            end
         end
         ST_SEND2: begin
            if (xfer && index == 4'd15) begin
               // A `done` on the final transfer chains straight into the next frame.
               index_n = 4'd0;
               if (done) begin
                  capture = 1'b1;
                  state_n = ST_SEND1;
               end else begin
                  state_n = ST_IDLE;
               end
            end else begin
               if (done) overrun_set = 1'b1;
               if (xfer) index_n = index + 4'd1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            index_n = 4'd0;
         end
      endcase
   end

   assign raw1 = snap1[index];
   assign raw2 = snap2[index];

   always_comb begin
      sat1 = raw1;
      if ($signed(raw1) > $signed(SAT_MAX))      sat1 = SAT_MAX;
      else if ($signed(raw1) < $signed(SAT_MIN)) sat1 = SAT_MIN;
   end

   always_comb begin
      out_data = '0;
      if (state == ST_SEND1)      out_data = (SAT_BANK1 != 0) ? sat1 : raw1;
      else if (state == ST_SEND2) out_data = raw2;
   end

   assign out_valid = (state != ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign out_bank  = (state == ST_SEND2);
   assign out_row   = index[3:2];
   assign out_col   = index[1:0];
   assign out_last  = (state == ST_SEND2) && (index == 4'd15);
   assign dbg_state = state;

endmodule
